// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multicycle MIPS controller
// Purpose: state encodings, opcode/funct constants, ALU/npc/wb/reg_dst codes
//          and the instruction class used between decoder and FSM.
// Ports:   none (package).
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_OR    = 3'd2;
  localparam logic [2:0] ALU_FUNCT = 3'd3;
  localparam logic [2:0] ALU_LUI   = 3'd4;

  localparam logic [2:0] NPC_PC4  = 3'd0;
  localparam logic [2:0] NPC_BR   = 3'd1;
  localparam logic [2:0] NPC_JUMP = 3'd2;
  localparam logic [2:0] NPC_RS   = 3'd3;
  localparam logic [2:0] NPC_TRAP = 3'd4;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] RD_RD = 2'd0;
  localparam logic [1:0] RD_RT = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  typedef enum logic [3:0] {
    C_R, C_JR, C_ORI, C_ADDI, C_LUI, C_LW, C_SW,
    C_BEQ, C_BNE, C_J, C_JAL, C_ILL
  } iclass_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - opcode/funct classifier for the multicycle controller
// Purpose: map the IR opcode/funct fields to an instruction class.
// Ports:   i_opcode/i_funct - IR fields; o_class - instruction class;
//          o_illegal - opcode not recognised.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output iclass_t    o_class,
  output logic       o_illegal
);

  always_comb begin
    o_class = C_ILL;
    case (i_opcode)
      OP_R:    o_class = (i_funct == FUNCT_JR) ? C_JR : C_R;
      OP_ORI:  o_class = C_ORI;
      OP_ADDI: o_class = C_ADDI;
      OP_LUI:  o_class = C_LUI;
      OP_LW:   o_class = C_LW;
      OP_SW:   o_class = C_SW;
      OP_BEQ:  o_class = C_BEQ;
      OP_BNE:  o_class = C_BNE;
      OP_J:    o_class = C_J;
      OP_JAL:  o_class = C_JAL;
      default: o_class = C_ILL;
    endcase
  end

  assign o_illegal = (o_class == C_ILL);

endmodule

// File: rtl/mc_ctrl_hs.sv
// rtl/mc_ctrl_hs.sv - multicycle MIPS control FSM with memory ready handshake
// Purpose: sequences IF/ID/EX/MEM/WB/TRAP and drives datapath controls.
// Ports:   clk/rst - clock, async active-high reset; opcode/funct - IR fields;
//          alu_zero - ALU zero flag; mem_ready - memory access completes;
//          ir_write, pc_write_en, reg_write_en, reg_dst, wb_sel, ext_sign,
//          alu_src, alu_op, mem_read_en, mem_write_en, npc_src - datapath
//          controls; illegal - in TRAP; retire - instruction completes;
//          state_o - current state.
module mc_ctrl_hs
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_HS  = 1,
  parameter int TRAP_EN = 1,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               ir_write,
  output logic               pc_write_en,
  output logic               reg_write_en,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wb_sel,
  output logic               ext_sign,
  output logic               alu_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               mem_read_en,
  output logic               mem_write_en,
  output logic [2:0]         npc_src,
  output logic               illegal,
  output logic               retire,
  output logic [2:0]         state_o
);

  state_t     r_state;
  state_t     w_next;
  iclass_t    w_class;
  logic       w_illegal;
  logic       w_ready;
  logic [2:0] w_alu_op;

  // Without the handshake every access completes in one cycle.
  assign w_ready = (MEM_HS != 0) ? mem_ready : 1'b1;

  mc_ctrl_decode u_decode (
    .i_opcode  (opcode),
    .i_funct   (funct),
    .o_class   (w_class),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IF;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = S_IF;
    ir_write     = 1'b0;
    pc_write_en  = 1'b0;
    reg_write_en = 1'b0;
    reg_dst      = RD_RD;
    wb_sel       = WB_ALU;
    ext_sign     = 1'b0;
    alu_src      = 1'b0;
    w_alu_op     = ALU_ADD;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    npc_src      = NPC_PC4;
    illegal      = 1'b0;
    case (r_state)
      S_IF: begin
        mem_read_en = 1'b1;
        ir_write    = w_ready;
        w_next      = w_ready ? S_ID : S_IF;
      end
      S_ID: begin
        w_next = (w_illegal && (TRAP_EN != 0)) ? S_TRAP : S_EX;
      end
      S_EX: begin
        case (w_class)
          C_R: begin
            w_alu_op = ALU_FUNCT;
            w_next   = S_WB;
          end
          C_JR: begin
            pc_write_en = 1'b1;
            npc_src     = NPC_RS;
          end
          C_ORI: begin
            alu_src  = 1'b1;
            w_alu_op = ALU_OR;
            w_next   = S_WB;
          end
          C_ADDI: begin
            alu_src  = 1'b1;
            ext_sign = 1'b1;
            w_alu_op = ALU_ADD;
            w_next   = S_WB;
          end
          C_LUI: begin
            alu_src  = 1'b1;
            w_alu_op = ALU_LUI;
            w_next   = S_WB;
          end
          C_LW, C_SW: begin
            alu_src  = 1'b1;
            ext_sign = 1'b1;
            w_alu_op = ALU_ADD;
            w_next   = S_MEM;
          end
          C_BEQ, C_BNE: begin
            w_alu_op    = ALU_SUB;
            ext_sign    = 1'b1;
            pc_write_en = 1'b1;
            // Taken when the zero flag matches the branch sense.
            npc_src     = (alu_zero == (w_class == C_BEQ)) ? NPC_BR : NPC_PC4;
          end
          C_J: begin
            pc_write_en = 1'b1;
            npc_src     = NPC_JUMP;
          end
          C_JAL: begin
            pc_write_en  = 1'b1;
            npc_src      = NPC_JUMP;
            reg_write_en = 1'b1;
            reg_dst      = RD_RA;
            wb_sel       = WB_PC4;
          end
          default: begin
            // Unknown opcode when traps are disabled: retire as a NOP.
            pc_write_en = 1'b1;
            npc_src     = NPC_PC4;
          end
        endcase
      end
      S_MEM: begin
        if (w_class == C_LW) begin
          mem_read_en = 1'b1;
          w_next      = w_ready ? S_WB : S_MEM;
        end else if (w_class == C_SW) begin
          mem_write_en = 1'b1;
          pc_write_en  = w_ready;
          w_next       = w_ready ? S_IF : S_MEM;
        end
      end
      S_WB: begin
        reg_write_en = 1'b1;
        pc_write_en  = 1'b1;
        case (w_class)
          C_LW: begin
            reg_dst = RD_RT;
            wb_sel  = WB_MEM;
          end
          C_ORI, C_ADDI, C_LUI: reg_dst = RD_RT;
          default:              reg_dst = RD_RD;
        endcase
      end
      S_TRAP: begin
        illegal     = 1'b1;
        pc_write_en = 1'b1;
        npc_src     = NPC_TRAP;
      end
      default: w_next = S_IF;
    endcase
  end

  assign alu_op  = ALUOP_W'(w_alu_op);
  assign retire  = pc_write_en;
  assign state_o = r_state;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// tb/tb_mc_ctrl_hs.sv - self-checking bench for mc_ctrl_hs
module tb_mc_ctrl_hs;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;

  always #5 clk = ~clk;

  // Main instance: handshake and traps enabled.
  logic       irw_m, pcw_m, rw_m, ext_m, asrc_m, mrd_m, mwr_m, ill_m, ret_m;
  logic [1:0] rdst_m, wsel_m;
  logic [2:0] aop_m, npc_m, st_m;
  // Alternate instance: single-cycle memory, traps disabled.
  logic       irw_a, pcw_a, rw_a, ext_a, asrc_a, mrd_a, mwr_a, ill_a, ret_a;
  logic [1:0] rdst_a, wsel_a;
  logic [2:0] aop_a, npc_a, st_a;

  mc_ctrl_hs dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .ir_write(irw_m), .pc_write_en(pcw_m),
    .reg_write_en(rw_m), .reg_dst(rdst_m), .wb_sel(wsel_m), .ext_sign(ext_m),
    .alu_src(asrc_m), .alu_op(aop_m), .mem_read_en(mrd_m), .mem_write_en(mwr_m),
    .npc_src(npc_m), .illegal(ill_m), .retire(ret_m), .state_o(st_m)
  );

  mc_ctrl_hs #(.MEM_HS(0), .TRAP_EN(0), .ALUOP_W(3)) dut_alt (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .ir_write(irw_a), .pc_write_en(pcw_a),
    .reg_write_en(rw_a), .reg_dst(rdst_a), .wb_sel(wsel_a), .ext_sign(ext_a),
    .alu_src(asrc_a), .alu_op(aop_a), .mem_read_en(mrd_a), .mem_write_en(mwr_a),
    .npc_src(npc_a), .illegal(ill_a), .retire(ret_a), .state_o(st_a)
  );

  logic [21:0] pk_m, pk_a;
  assign pk_m = {st_m, irw_m, pcw_m, rw_m, rdst_m, wsel_m, ext_m, asrc_m, aop_m,
                 mrd_m, mwr_m, npc_m, ill_m, ret_m};
  assign pk_a = {st_a, irw_a, pcw_a, rw_a, rdst_a, wsel_a, ext_a, asrc_a, aop_a,
                 mrd_a, mwr_a, npc_a, ill_a, ret_a};

  typedef struct {
    logic        rst;
    logic        sel;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [21:0] exp;
    int          idx;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  vec_t cur;
  logic [21:0] got;
  int n_checks = 0;
  int n_fail = 0;

  localparam logic [5:0] R = 6'b000000, ORI = 6'b001101, ADDI = 6'b001000;
  localparam logic [5:0] LUI = 6'b001111, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010;
  localparam logic [5:0] JAL = 6'b000011, BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_JR = 6'b001000;

  // Expected output word; retire always mirrors pc_write_en.
  function automatic logic [21:0] x(input int st, input int irw, input int pcw,
      input int rw, input int rdst, input int wsel, input int ext, input int asrc,
      input int aop, input int mrd, input int mwr, input int npc, input int ill);
    return {3'(st), 1'(irw), 1'(pcw), 1'(rw), 2'(rdst), 2'(wsel), 1'(ext),
            1'(asrc), 3'(aop), 1'(mrd), 1'(mwr), 3'(npc), 1'(ill), 1'(pcw)};
  endfunction

  task automatic add(input int r, input int sel, input logic [5:0] op,
                     input logic [5:0] fn, input int z, input int rdy,
                     input logic [21:0] e);
    vec_t v;
    v.rst = 1'(r); v.sel = 1'(sel); v.op = op; v.fn = fn;
    v.z = 1'(z); v.rdy = 1'(rdy); v.exp = e; v.idx = vecs.size();
    vecs.push_back(v);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      got = cur.sel ? pk_a : pk_m;
      n_checks++;
      if (got !== cur.exp) begin
        n_fail++;
        $display("FAIL ctl_row%0d dut%0d: got %h expected %h",
                 cur.idx, cur.sel, got, cur.exp);
      end
    end
  end

  initial begin
    logic [21:0] e_ifr, e_ifw, e_id, e_wbi, e_wbr, e_wbl, e_exa, e_meml;
    e_ifr  = x(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    e_ifw  = x(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    e_id   = x(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_wbi  = x(4, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    e_wbr  = x(4, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_wbl  = x(4, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    e_exa  = x(2, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    e_meml = x(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // Reset state with mem_ready low.
    add(1, 0, R, 0, 0, 0, e_ifw);
    // ORI, ADDI, LUI, R-add back to back, 4 cycles each.
    add(0, 0, ORI, 0, 0, 1, e_ifr); add(0, 0, ORI, 0, 0, 1, e_id);
    add(0, 0, ORI, 0, 0, 1, x(2, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
    add(0, 0, ORI, 0, 0, 1, e_wbi);
    add(0, 0, ADDI, 0, 0, 1, e_ifr); add(0, 0, ADDI, 0, 0, 1, e_id);
    add(0, 0, ADDI, 0, 0, 1, e_exa); add(0, 0, ADDI, 0, 0, 1, e_wbi);
    add(0, 0, LUI, 0, 0, 1, e_ifr); add(0, 0, LUI, 0, 0, 1, e_id);
    add(0, 0, LUI, 0, 0, 1, x(2, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0));
    add(0, 0, LUI, 0, 0, 1, e_wbi);
    add(0, 0, R, F_ADD, 0, 1, e_ifr); add(0, 0, R, F_ADD, 0, 1, e_id);
    add(0, 0, R, F_ADD, 0, 1, x(2, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0));
    add(0, 0, R, F_ADD, 0, 1, e_wbr);
    // LW: 3 IF wait states, 2 MEM wait states, 10 cycles total.
    for (int i = 0; i < 3; i++) add(0, 0, LW, 0, 0, 0, e_ifw);
    add(0, 0, LW, 0, 0, 1, e_ifr); add(0, 0, LW, 0, 0, 1, e_id);
    add(0, 0, LW, 0, 0, 1, e_exa);
    add(0, 0, LW, 0, 0, 0, e_meml); add(0, 0, LW, 0, 0, 0, e_meml);
    add(0, 0, LW, 0, 0, 1, e_meml); add(0, 0, LW, 0, 0, 1, e_wbl);
    // Branches in both senses.
    add(0, 0, BEQ, 0, 1, 1, e_ifr); add(0, 0, BEQ, 0, 1, 1, e_id);
    add(0, 0, BEQ, 0, 1, 1, x(2, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0));
    add(0, 0, BNE, 0, 1, 1, e_ifr); add(0, 0, BNE, 0, 1, 1, e_id);
    add(0, 0, BNE, 0, 1, 1, x(2, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    add(0, 0, BNE, 0, 0, 1, e_ifr); add(0, 0, BNE, 0, 0, 1, e_id);
    add(0, 0, BNE, 0, 0, 1, x(2, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0));
    add(0, 0, BEQ, 0, 0, 1, e_ifr); add(0, 0, BEQ, 0, 0, 1, e_id);
    add(0, 0, BEQ, 0, 0, 1, x(2, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    // Jumps.
    add(0, 0, J, 0, 0, 1, e_ifr); add(0, 0, J, 0, 0, 1, e_id);
    add(0, 0, J, 0, 0, 1, x(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
    add(0, 0, JAL, 0, 0, 1, e_ifr); add(0, 0, JAL, 0, 0, 1, e_id);
    add(0, 0, JAL, 0, 0, 1, x(2, 0, 1, 1, 2, 2, 0, 0, 0, 0, 0, 2, 0));
    add(0, 0, R, F_JR, 0, 1, e_ifr); add(0, 0, R, F_JR, 0, 1, e_id);
    add(0, 0, R, F_JR, 0, 1, x(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0));
    // Illegal opcode traps.
    add(0, 0, BAD, 0, 0, 1, e_ifr); add(0, 0, BAD, 0, 0, 1, e_id);
    add(0, 0, BAD, 0, 0, 1, x(5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 1));
    // SW with ready memory.
    add(0, 0, SW, 0, 0, 1, e_ifr); add(0, 0, SW, 0, 0, 1, e_id);
    add(0, 0, SW, 0, 0, 1, e_exa);
    add(0, 0, SW, 0, 0, 1, x(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    // SW stalled in MEM, then reset mid-stall.
    add(0, 0, SW, 0, 0, 1, e_ifr); add(0, 0, SW, 0, 0, 1, e_id);
    add(0, 0, SW, 0, 0, 1, e_exa);
    add(0, 0, SW, 0, 0, 0, x(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    add(0, 0, SW, 0, 0, 0, x(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    add(1, 0, SW, 0, 0, 0, e_ifw);
    add(0, 0, SW, 0, 0, 1, e_ifr); add(0, 0, SW, 0, 0, 1, e_id);
    // Alternate instance: reset both, then NOP-retire and LW ignoring mem_ready.
    add(1, 0, R, 0, 0, 0, e_ifw);
    add(0, 1, BAD, 0, 0, 0, e_ifr); add(0, 1, BAD, 0, 0, 0, e_id);
    add(0, 1, BAD, 0, 0, 0, x(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, LW, 0, 0, 0, e_ifr); add(0, 1, LW, 0, 0, 0, e_id);
    add(0, 1, LW, 0, 0, 0, e_exa); add(0, 1, LW, 0, 0, 0, e_meml);
    add(0, 1, LW, 0, 0, 0, e_wbl); add(0, 1, LW, 0, 0, 0, e_ifr);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; opcode = vecs[i].op; funct = vecs[i].fn;
      alu_zero = vecs[i].z; mem_ready = vecs[i].rdy;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
